// File: rtl/counter_event_pkg.sv
// Shared types for the counter event monitor.
// evt_code_e : event codes as they appear on evt_code.
// state_e    : monitor FSM states.
// evt_rec_t  : code/value part of a queued record; the timestamp is appended
//              by the top because its width is a module parameter.
package counter_event_pkg;

    typedef enum logic [1:0] {
        EvtLoad   = 2'd0,
        EvtWrapUp = 2'd1,
        EvtWrapDn = 2'd2,
        EvtErr    = 2'd3
    } evt_code_e;

    typedef enum logic {
        StInit  = 1'b0,
        StTrack = 1'b1
    } state_e;

    typedef struct packed {
        evt_code_e  code;
        logic [3:0] value;
    } evt_rec_t;

    localparam logic [7:0] WrapCntMax = 8'd255;

endpackage

// File: rtl/counter_event_monitor_if.sv
// Event stream between the monitor and its consumer.
// master : monitor side (drives valid/code/value/time, receives ready).
// slave  : consumer side.
interface counter_event_monitor_if #(
    parameter int unsigned TS_W = 8
) ();
    logic            evt_valid;
    logic            evt_ready;
    logic [1:0]      evt_code;
    logic [3:0]      evt_value;
    logic [TS_W-1:0] evt_time;

    modport master (
        output evt_valid,
        output evt_code,
        output evt_value,
        output evt_time,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_code,
        input  evt_value,
        input  evt_time,
        output evt_ready
    );
endinterface

// File: rtl/counter_event_fifo.sv
// Record FIFO for the counter event monitor.
// Ports: clk, rst (async active-low), push/push_rec (write request),
//        pop_ready (consumer ready), valid/head_rec (head record, zero when empty),
//        drop (push refused because full with no pop this cycle).
// A push into a full FIFO is accepted when a pop happens on the same edge.
module counter_event_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned REC_W      = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [REC_W-1:0] push_rec,
    input  logic             pop_ready,
    output logic             valid,
    output logic [REC_W-1:0] head_rec,
    output logic             drop
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wptr_q, rptr_q;
    logic [REC_W-1:0] mem_q [FIFO_DEPTH];
    logic             empty, full, pop_en, push_en;

    always_comb begin
        empty    = (wptr_q == rptr_q);
        full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop_en   = pop_ready && !empty;
        push_en  = push && (!full || pop_en);
        drop     = push && !push_en;
        valid    = !empty;
        head_rec = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_en) wptr_q <= wptr_q + 1'b1;
            if (pop_en)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wptr_q[AW-1:0]] <= push_rec;
    end
endmodule

// File: rtl/counter_event_monitor.sv
// Watches a 4-bit up/down counter and queues LOAD / WRAP_UP / WRAP_DN (and,
// with COUNTER_EVENT_MONITOR_CHECK_EN defined, ERR) records with timestamps.
// Ports: clk, rst (async active-low); load/updown/data mirror the counter's
//        commands, count is its output; clr clears wrap_cnt/ovf/err;
//        evt (master) carries the FIFO head record; wrap_cnt counts wraps
//        (saturating); ovf flags a dropped event; err (macro only) flags a
//        count that did not follow the previous command.
module counter_event_monitor
    import counter_event_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TS_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       updown,
    input  logic [3:0] data,
    input  logic [3:0] count,
    input  logic       clr,
    counter_event_monitor_if.master evt,
    output logic [7:0] wrap_cnt,
    output logic       ovf
`ifdef COUNTER_EVENT_MONITOR_CHECK_EN
    ,
    output logic       err
`endif
);
    localparam int unsigned REC_W = $bits(evt_rec_t) + TS_W;

    state_e          state_q, state_d;
    logic [TS_W-1:0] ts_q;
    logic            prev_load, prev_updown;
    logic [3:0]      prev_data, prev_count;
    logic [7:0]      wrap_cnt_q;
    logic            ovf_q;
    logic            evt_det, evt_wrap, evt_err, fifo_drop;
    evt_rec_t        evt_rec, head_rec;
    logic [TS_W-1:0] head_ts;
    logic            err_hit;

`ifdef COUNTER_EVENT_MONITOR_CHECK_EN
    logic [3:0] exp_count;
    logic       err_q;
    always_comb begin
        exp_count = prev_load ? prev_data
                  : (prev_updown ? prev_count + 4'd1 : prev_count - 4'd1);
        err_hit   = (count != exp_count);
    end
`else
    logic unused_prev_data;
    assign unused_prev_data = ^prev_data;
    assign err_hit          = 1'b0;
`endif

    // Next state and event detection; priority ERR > LOAD > WRAP.
    always_comb begin
        state_d  = state_q;
        evt_det  = 1'b0;
        evt_wrap = 1'b0;
        evt_err  = 1'b0;
        evt_rec  = '{code: EvtLoad, value: count};
        unique case (state_q)
            StInit: state_d = StTrack;
            StTrack: begin
                if (err_hit) begin
                    evt_det      = 1'b1;
                    evt_err      = 1'b1;
                    evt_rec.code = EvtErr;
                end else if (prev_load) begin
                    evt_det      = 1'b1;
                end else if (prev_updown && prev_count == 4'd15 && count == 4'd0) begin
                    evt_det      = 1'b1;
                    evt_wrap     = 1'b1;
                    evt_rec.code = EvtWrapUp;
                end else if (!prev_updown && prev_count == 4'd0 && count == 4'd15) begin
                    evt_det      = 1'b1;
                    evt_wrap     = 1'b1;
                    evt_rec.code = EvtWrapDn;
                end
            end
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StInit;
            ts_q        <= '0;
            prev_load   <= 1'b0;
            prev_updown <= 1'b0;
            prev_data   <= '0;
            prev_count  <= '0;
            wrap_cnt_q  <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_q + 1'b1;
            prev_load   <= load;
            prev_updown <= updown;
            prev_data   <= data;
            prev_count  <= count;
            if (clr) begin
                wrap_cnt_q <= '0;
                ovf_q      <= 1'b0;
            end else begin
                if (evt_wrap && wrap_cnt_q != WrapCntMax) wrap_cnt_q <= wrap_cnt_q + 8'd1;
                if (fifo_drop) ovf_q <= 1'b1;
            end
        end
    end

`ifdef COUNTER_EVENT_MONITOR_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (clr) begin
            err_q <= 1'b0;
        end else if (evt_err) begin
            err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    logic unused_evt_err;
    assign unused_evt_err = evt_err;
`endif

    counter_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .REC_W      (REC_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (evt_det),
        .push_rec  ({evt_rec, ts_q}),
        .pop_ready (evt.evt_ready),
        .valid     (evt.evt_valid),
        .head_rec  ({head_rec, head_ts}),
        .drop      (fifo_drop)
    );

    assign evt.evt_code  = head_rec.code;
    assign evt.evt_value = head_rec.value;
    assign evt.evt_time  = head_ts;
    assign wrap_cnt      = wrap_cnt_q;
    assign ovf           = ovf_q;
endmodule

// File: tb/tb_counter_event_monitor.sv
module tb_counter_event_monitor;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0, updown = 1'b1, clr = 1'b0, rdy = 1'b0;
    logic [3:0] data = 4'd0, cnt = 4'd0;
    logic [7:0] wrap_cnt;
    logic       ovf, err_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    counter_event_monitor_if #(.TS_W(8)) ev_if ();
    assign ev_if.evt_ready = rdy;

    counter_event_monitor #(
        .FIFO_DEPTH (DEPTH),
        .TS_W       (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .updown   (updown),
        .data     (data),
        .count    (cnt),
        .clr      (clr),
        .evt      (ev_if),
        .wrap_cnt (wrap_cnt),
        .ovf      (ovf)
`ifdef COUNTER_EVENT_MONITOR_CHECK_EN
        ,
        .err      (err_o)
`endif
    );
`ifndef COUNTER_EVENT_MONITOR_CHECK_EN
    assign err_o = 1'b0;
`endif

    // Observed view: valid, code, value, time, wrap_cnt, ovf, err.
    logic [24:0] dut_view;
    assign dut_view = {ev_if.evt_valid, ev_if.evt_code, ev_if.evt_value, ev_if.evt_time,
                       wrap_cnt, ovf, err_o};

    // ---------------- reference model ----------------
    typedef struct {
        logic [1:0] code;
        logic [3:0] value;
        logic [7:0] stamp;
    } rec_t;

    rec_t       mq[$];
    logic       h_load, h_updown;
    logic [3:0] h_data, h_count;
    logic       m_track, m_ovf, m_err;
    logic [7:0] m_ts, m_wrap;

    function automatic logic [24:0] model_view();
        rec_t hd;
        hd = '{2'd0, 4'd0, 8'd0};
        if (mq.size() != 0) hd = mq[0];
        return {mq.size() != 0, hd.code, hd.value, hd.stamp, m_wrap, m_ovf, m_err};
    endfunction

    task automatic model_reset();
        mq.delete();
        h_load = 0; h_updown = 0; h_data = 0; h_count = 0;
        m_track = 0; m_ovf = 0; m_err = 0; m_ts = 0; m_wrap = 0;
    endtask

    // What happens at the coming clock edge, from the current inputs and history.
    task automatic model_edge();
        logic       ev, chk, pop, full, dropped;
        logic [1:0] c;
        logic [3:0] exp;
        ev = 0; c = 0; dropped = 0;
`ifdef COUNTER_EVENT_MONITOR_CHECK_EN
        chk = 1;
`else
        chk = 0;
`endif
        exp = h_load ? h_data : (h_updown ? h_count + 4'd1 : h_count - 4'd1);
        if (m_track) begin
            if (chk && cnt != exp) begin ev = 1; c = 3; end
            else if (h_load) begin ev = 1; c = 0; end
            else if (h_updown && h_count == 15 && cnt == 0) begin ev = 1; c = 1; end
            else if (!h_updown && h_count == 0 && cnt == 15) begin ev = 1; c = 2; end
        end
        pop  = (mq.size() != 0) && rdy;
        full = (mq.size() == DEPTH);
        if (pop) void'(mq.pop_front());
        if (ev) begin
            if (!full || pop) mq.push_back('{c, cnt, m_ts});
            else dropped = 1;
        end
        if (clr) begin
            m_wrap = 0; m_ovf = 0; m_err = 0;
        end else begin
            if (ev && (c == 1 || c == 2) && m_wrap != 8'd255) m_wrap = m_wrap + 8'd1;
            if (dropped) m_ovf = 1;
            if (ev && c == 3) m_err = 1;
        end
        m_ts = m_ts + 8'd1;
        m_track = 1;
        h_load = load; h_updown = updown; h_data = data; h_count = cnt;
    endtask

    // One clock: model, edge, then the external counter follows its commands.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        cnt = h_load ? h_data : (h_updown ? cnt + 4'd1 : cnt - 4'd1);
    endtask

    task automatic do_reset();
        rst = 0; load = 0; updown = 1; data = 0; clr = 0; rdy = 0; cnt = 0;
        model_reset();
        #3;
        @(negedge clk);
        rst = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_tests++;
        if (dut_view !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_view, 25'd0);
        end
    endtask

    task automatic test_load();
        do_reset();
        rdy = 1; load = 1; data = 4'd9;
        tick();
        load = 0; updown = 1;
        tick();
        n_tests++;
        if ({ev_if.evt_valid, ev_if.evt_code, ev_if.evt_value} !== {1'b1, 2'd0, 4'd9}) begin
            n_fail++;
            $display("FAIL load_event: got v%b c%0d val%0d expected v1 c0 val9",
                     ev_if.evt_valid, ev_if.evt_code, ev_if.evt_value);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (dut_view !== model_view()) begin
                n_fail++;
                $display("FAIL load_follow[%0d]: got %h expected %h", i, dut_view, model_view());
            end
        end
    endtask

    task automatic test_wrap_up();
        bit seen;
        seen = 0;
        do_reset();
        rdy = 1; load = 1; data = 4'd14;
        tick();
        load = 0; updown = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ev_if.evt_valid && ev_if.evt_code == 2'd1 && ev_if.evt_value == 4'd0) seen = 1;
            n_tests++;
            if (dut_view !== model_view()) begin
                n_fail++;
                $display("FAIL wrap_up[%0d]: got %h expected %h", i, dut_view, model_view());
            end
        end
        n_tests++;
        if (!seen || wrap_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL wrap_up_count: got seen=%0b wrap_cnt=%0d expected seen=1 wrap_cnt=1",
                     seen, wrap_cnt);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] last_t;
        int         drained;
        do_reset();
        rdy = 0; load = 1; data = 4'd1;
        tick();
        load = 0; updown = 0;
        for (int i = 0; i < 80; i++) tick();
        n_tests++;
        if (ovf !== 1'b1 || dut_view !== model_view()) begin
            n_fail++;
            $display("FAIL overflow_flag: got %h expected %h", dut_view, model_view());
        end
        rdy = 1; updown = 1; drained = 0; last_t = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            n_tests++;
            if (dut_view !== model_view()) begin
                n_fail++;
                $display("FAIL overflow_drain[%0d]: got %h expected %h", i, dut_view,
                         model_view());
            end
            if (ev_if.evt_valid) begin
                if (drained != 0 && ev_if.evt_time <= last_t) begin
                    n_fail++;
                    $display("FAIL overflow_order: got time %0d expected above %0d",
                             ev_if.evt_time, last_t);
                end
                last_t = ev_if.evt_time;
                drained++;
            end
            tick();
        end
        n_tests++;
        if (drained != DEPTH) begin
            n_fail++;
            $display("FAIL overflow_depth: got %0d records expected %0d", drained, DEPTH);
        end
    endtask

    task automatic test_clr();
        bool_hit: begin end
        do_reset();
        rdy = 0; load = 1; data = 4'd1;
        tick();
        load = 0; updown = 0;
        for (int i = 0; i < 40; i++) begin
            clr = (h_count == 4'd0 && cnt == 4'd15 && i > 20);
            tick();
            if (clr) begin
                clr = 0;
                n_tests++;
                if (wrap_cnt !== 8'd0 || ovf !== 1'b0 || dut_view !== model_view()) begin
                    n_fail++;
                    $display("FAIL clr_wrap_dn: got %h expected %h", dut_view, model_view());
                end
            end
        end
        clr = 0;
        rdy = 1;
        for (int i = 0; i < 6; i++) begin
            n_tests++;
            if (dut_view !== model_view()) begin
                n_fail++;
                $display("FAIL clr_drain[%0d]: got %h expected %h", i, dut_view, model_view());
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            load   = ($urandom_range(0, 7) == 0);
            updown = 1'($urandom_range(0, 1));
            data   = 4'($urandom);
            clr    = ($urandom_range(0, 31) == 0);
            rdy    = ($urandom_range(0, 3) == 0);
            tick();
            n_tests++;
            if (dut_view !== model_view()) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, dut_view, model_view());
            end
        end
        clr = 0;
    endtask

`ifdef COUNTER_EVENT_MONITOR_CHECK_EN
    task automatic test_err();
        do_reset();
        rdy = 1; load = 1; data = 4'd4;
        tick();
        load = 0; updown = 1;
        tick();
        cnt = 4'd7;
        tick();
        n_tests++;
        if ({ev_if.evt_valid, ev_if.evt_code, ev_if.evt_value, err_o} !==
            {1'b1, 2'd3, 4'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL err_event: got %h expected %h", dut_view, model_view());
        end
        for (int i = 0; i < 3; i++) tick();
        n_tests++;
        if (err_o !== 1'b1 || dut_view !== model_view()) begin
            n_fail++;
            $display("FAIL err_sticky: got %h expected %h", dut_view, model_view());
        end
        clr = 1;
        tick();
        clr = 0;
        n_tests++;
        if (err_o !== 1'b0 || dut_view !== model_view()) begin
            n_fail++;
            $display("FAIL err_clr: got %h expected %h", dut_view, model_view());
        end
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        rdy = 0; load = 1; data = 4'd3;
        for (int i = 0; i < 4; i++) tick();
        n_tests++;
        if (dut_view !== model_view() || mq.size() != 3) begin
            n_fail++;
            $display("FAIL reset_mid_fill: got %h expected %h", dut_view, model_view());
        end
        #2;
        rst = 0;
        #1;
        n_tests++;
        if (ev_if.evt_valid !== 1'b0 || dut_view !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h expected %h", dut_view, 25'd0);
        end
        do_reset();
        rdy = 1; load = 1; data = 4'd6;
        tick();
        n_tests++;
        if (ev_if.evt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_init: got valid %b expected 0", ev_if.evt_valid);
        end
        load = 0;
        tick();
        n_tests++;
        if ({ev_if.evt_valid, ev_if.evt_code, ev_if.evt_value} !== {1'b1, 2'd0, 4'd6} ||
            dut_view !== model_view()) begin
            n_fail++;
            $display("FAIL reset_mid_track: got %h expected %h", dut_view, model_view());
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_wrap_up();
        test_overflow();
        test_clr();
        test_random();
`ifdef COUNTER_EVENT_MONITOR_CHECK_EN
        test_err();
`endif
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Guards against a stuck run.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
